// File: rtl/enigma_pkg.sv
// Shared types and scan-code helpers for the keystroke front end.
// Parser states, PS/2 set-2 prefix bytes and the letter lookup.
package enigma_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_BREAK     = 2'd1,
    S_EXT       = 2'd2,
    S_EXT_BREAK = 2'd3
  } ps_state_t;

  typedef logic [4:0] letter_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Set-2 make code to letter index A=1..Z=26; 0 means not a letter.
  function automatic letter_t sc_to_letter(input logic [7:0] sc);
    letter_t l;
    case (sc)
      8'h1C:   l = 5'd1;
      8'h32:   l = 5'd2;
      8'h21:   l = 5'd3;
      8'h23:   l = 5'd4;
      8'h24:   l = 5'd5;
      8'h2B:   l = 5'd6;
      8'h34:   l = 5'd7;
      8'h33:   l = 5'd8;
      8'h43:   l = 5'd9;
      8'h3B:   l = 5'd10;
      8'h42:   l = 5'd11;
      8'h4B:   l = 5'd12;
      8'h3A:   l = 5'd13;
      8'h31:   l = 5'd14;
      8'h44:   l = 5'd15;
      8'h4D:   l = 5'd16;
      8'h15:   l = 5'd17;
      8'h2D:   l = 5'd18;
      8'h1B:   l = 5'd19;
      8'h2C:   l = 5'd20;
      8'h3C:   l = 5'd21;
      8'h2A:   l = 5'd22;
      8'h1D:   l = 5'd23;
      8'h22:   l = 5'd24;
      8'h35:   l = 5'd25;
      8'h1A:   l = 5'd26;
      default: l = 5'd0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/letter_fifo.sv
// Small letter queue with a head output that holds the last popped
// value while empty, so the consumer never sees stale RAM contents.
module letter_fifo
  import enigma_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  letter_t                i_din,
  input  logic                   i_pop,
  output letter_t                o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  letter_t         r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  letter_t         r_last;
  logic            w_wr;
  logic            w_rd;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // A push into a full queue only lands when a pop frees a slot.
  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);

  assign o_dout = o_empty ? r_last : r_mem[r_rd_ptr];

  // Storage array; no reset needed since reads are gated by count.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers, occupancy and the held head value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr];
      end
      r_count <= r_count
               + {{AW{1'b0}}, w_wr}
               - {{AW{1'b0}}, w_rd};
    end
  end

endmodule

// File: rtl/keystroke_sequencer.sv
// PS/2 make/break parser feeding a letter queue for the rotor stepper.
// Optional typematic filter: define REPEAT_FILTER_EN.
module keystroke_sequencer
  import enigma_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             ps2_byte,
  input  logic                   ps2_valid,
  output logic [4:0]             letter_o,
  output logic                   letter_valid,
  input  logic                   letter_ready,
  output logic [$clog2(DEPTH):0] fill_o,
  output logic                   ovf_o,
  input  logic                   ovf_clr
);

  ps_state_t r_state;
  ps_state_t w_state_nxt;
  letter_t   w_sc_letter;
  logic      w_push;
  logic      w_pop;
  logic      w_full;
  logic      w_empty;
  logic      r_ovf;
  logic      w_drop;
  letter_t   w_head;

  assign w_sc_letter = sc_to_letter(ps2_byte);

`ifdef REPEAT_FILTER_EN
  logic [7:0] r_held;
  logic       w_is_repeat;

  assign w_is_repeat = (ps2_byte == r_held);

  // Remember the key currently held down; its break releases it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_held <= '0;
    end else if (ps2_valid) begin
      if (w_push)
        r_held <= ps2_byte;
      else if (r_state == S_BREAK && w_is_repeat)
        r_held <= '0;
    end
  end
`else
  logic w_is_repeat;

  assign w_is_repeat = 1'b0;
`endif

  // Parser state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Parser next state; only a valid byte moves it.
  always_comb begin
    w_state_nxt = r_state;
    if (ps2_valid) begin
      case (r_state)
        S_IDLE: begin
          if (ps2_byte == SC_BREAK)
            w_state_nxt = S_BREAK;
          else if (ps2_byte == SC_EXT)
            w_state_nxt = S_EXT;
        end
        S_BREAK:
          w_state_nxt = S_IDLE;
        S_EXT: begin
          if (ps2_byte == SC_BREAK)
            w_state_nxt = S_EXT_BREAK;
          else
            w_state_nxt = S_IDLE;
        end
        S_EXT_BREAK:
          w_state_nxt = S_IDLE;
        default:
          w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Parser output: plain letter make codes become queue pushes.
  always_comb begin
    w_push = 1'b0;
    if (ps2_valid && r_state == S_IDLE
        && w_sc_letter != '0)
      w_push = !w_is_repeat;
  end

  assign w_pop  = letter_valid && letter_ready;
  assign w_drop = w_push && w_full && !w_pop;

  // Sticky overflow flag; a fresh drop beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ovf <= 1'b0;
    else if (w_drop)
      r_ovf <= 1'b1;
    else if (ovf_clr)
      r_ovf <= 1'b0;
  end

  letter_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_sc_letter),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fill_o)
  );

  assign letter_o     = w_head;
  assign letter_valid = !w_empty;
  assign ovf_o        = r_ovf;

endmodule

// File: tb/tb_keystroke_sequencer.sv
// Bench for keystroke_sequencer: directed scenarios plus random traffic
// against a queue-based model of the scan-code rules.
module tb_keystroke_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ps2_byte;
  logic       ps2_valid;
  logic [4:0] letter_o;
  logic       letter_valid;
  logic       letter_ready;
  logic [2:0] fill_o;
  logic       ovf_o;
  logic       ovf_clr;

  keystroke_sequencer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_byte     (ps2_byte),
    .ps2_valid    (ps2_valid),
    .letter_o     (letter_o),
    .letter_valid (letter_valid),
    .letter_ready (letter_ready),
    .fill_o       (fill_o),
    .ovf_o        (ovf_o),
    .ovf_clr      (ovf_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: letter table, queue, sticky flag, prefix flags, held key.
  int codes [26] = '{'h1C, 'h32, 'h21, 'h23, 'h24, 'h2B, 'h34,
                     'h33, 'h43, 'h3B, 'h42, 'h4B, 'h3A, 'h31,
                     'h44, 'h4D, 'h15, 'h2D, 'h1B, 'h2C, 'h3C,
                     'h2A, 'h1D, 'h22, 'h35, 'h1A};

  function automatic int lookup(int b);
    for (int i = 0; i < 26; i++)
      if (codes[i] == b) return i + 1;
    return 0;
  endfunction

  int mq[$];
  int m_last = 0;
  bit m_ovf = 0;
  bit m_brk = 0;
  bit m_ext = 0;
  int m_held = 0;

  always @(posedge clk or posedge rst) begin
    int  l;
    bit  drop;
    if (rst) begin
      mq.delete();
      m_last = 0;
      m_ovf  = 0;
      m_brk  = 0;
      m_ext  = 0;
      m_held = 0;
    end else begin
      l    = 0;
      drop = 0;
      if (mq.size() > 0 && letter_ready)
        m_last = mq.pop_front();
      if (ps2_valid) begin
        if (m_brk) begin
          if (!m_ext && int'(ps2_byte) == m_held) m_held = 0;
          m_brk = 0;
          m_ext = 0;
        end else if (m_ext) begin
          if (ps2_byte == 8'hF0) m_brk = 1;
          else m_ext = 0;
        end else if (ps2_byte == 8'hF0) m_brk = 1;
        else if (ps2_byte == 8'hE0) m_ext = 1;
        else l = lookup(int'(ps2_byte));
      end
`ifdef REPEAT_FILTER_EN
      if (l != 0) begin
        if (int'(ps2_byte) == m_held) l = 0;
        else m_held = int'(ps2_byte);
      end
`endif
      if (l != 0) begin
        if (mq.size() < DEPTH) mq.push_back(l);
        else drop = 1;
      end
      m_ovf = drop ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
    end
  end

  // Compare process and accepted-letter log.
  int got[$];
  int vcnt = 0;
  bit prev_v = 0;
  int prev_l = 0;

  always @(negedge clk) begin
    check("valid", letter_valid, mq.size() > 0);
    check("fill", fill_o, mq.size());
    check("ovf", ovf_o, m_ovf);
    check("letter", letter_o, mq.size() > 0 ? mq[0] : m_last);
    if (rst) begin
      prev_v = 0;
    end else begin
      if (prev_v && letter_ready) got.push_back(prev_l);
      prev_v = letter_valid;
      prev_l = letter_o;
    end
    if (letter_valid) vcnt++;
  end

  function automatic int gv(int i);
    return got.size() > i ? got[i] : 255;
  endfunction

  task automatic cyc(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send(int b);
    ps2_byte  = 8'(b);
    ps2_valid = 1'b1;
    cyc(1);
    ps2_valid = 1'b0;
  endtask

  int cnt5;
  int r;

  initial begin
    rst          = 1'b1;
    ps2_byte     = '0;
    ps2_valid    = 1'b0;
    letter_ready = 1'b0;
    ovf_clr      = 1'b0;
    cyc(2);
    rst = 1'b0;
    check("rst_letter", letter_o, 0);
    check("rst_valid", letter_valid, 0);
    check("rst_fill", fill_o, 0);
    check("rst_ovf", ovf_o, 0);

    // Make, break of one key.
    letter_ready = 1'b1;
    got.delete();
    vcnt = 0;
    send('h1C); send('hF0); send('h1C);
    cyc(3);
    check("t1_count", got.size(), 1);
    check("t1_letter", gv(0), 1);
    check("t1_vcycles", vcnt, 1);

    // Fill past capacity, then drain in order.
    letter_ready = 1'b0;
    got.delete();
    send('h1A); send('h15); send('h2D); send('h1B); send('h2C);
    cyc(1);
    check("t2_fill", fill_o, 4);
    check("t2_ovf", ovf_o, 1);
    letter_ready = 1'b1;
    cyc(6);
    check("t2_count", got.size(), 4);
    check("t2_l0", gv(0), 26);
    check("t2_l1", gv(1), 17);
    check("t2_l2", gv(2), 18);
    check("t2_l3", gv(3), 19);
    check("t2_valid", letter_valid, 0);
    check("t2_hold", letter_o, 19);

    // Extended sequences push nothing; parser returns to idle.
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    check("t3_ovfclr", ovf_o, 0);
    got.delete();
    send('hE0); send('h1C); send('hE0); send('hF0); send('h1C);
    cyc(2);
    check("t3_fill", fill_o, 0);
    check("t3_none", got.size(), 0);
    send('h1C);
    cyc(2);
    check("t3_idle", gv(0), 1);

    // Push into a full queue alongside a pop.
    letter_ready = 1'b0;
    got.delete();
    send('h1C); send('h32); send('h21); send('h23);
    check("t4_full", fill_o, 4);
    letter_ready = 1'b1;
    send('h2A);
    letter_ready = 1'b0;
    check("t4_fill", fill_o, 4);
    check("t4_ovf", ovf_o, 0);
    letter_ready = 1'b1;
    cyc(6);
    check("t4_count", got.size(), 5);
    check("t4_first", gv(0), 1);
    check("t4_last", gv(4), 22);

    // Typematic repeats of E.
    got.delete();
    send('h24); send('h24); send('h24);
    send('hF0); send('h24); send('h24);
    cyc(3);
    cnt5 = 0;
    foreach (got[i]) if (got[i] == 5) cnt5++;
`ifdef REPEAT_FILTER_EN
    check("t5_events", cnt5, 2);
`else
    check("t5_events", cnt5, 4);
`endif

    // Reset mid-stream.
    letter_ready = 1'b0;
    send('h1C); send('h32); send('h21); send('hF0);
    check("t6_fill", fill_o, 3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("t6_letter", letter_o, 0);
    check("t6_valid", letter_valid, 0);
    check("t6_fill0", fill_o, 0);
    check("t6_ovf", ovf_o, 0);
    got.delete();
    letter_ready = 1'b1;
    send('h32);
    cyc(2);
    check("t6_next", gv(0), 2);

    // Random traffic with varying back-pressure.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5)       ps2_byte = 8'(codes[$urandom_range(0, 25)]);
      else if (r == 5) ps2_byte = 8'hF0;
      else if (r == 6) ps2_byte = 8'hE0;
      else if (r == 7) ps2_byte = 8'h24;
      else             ps2_byte = 8'($urandom);
      ps2_valid    = ($urandom_range(0, 2) != 0);
      letter_ready = ((i / 200) % 2 == 0)
                     ? ($urandom_range(0, 3) == 0)
                     : ($urandom_range(0, 3) != 0);
      ovf_clr      = ($urandom_range(0, 19) == 0);
      rst          = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    rst       = 1'b0;
    ps2_valid = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
